conv2_omem_reader: RTL and testbench

Drains the conv2 output memory (OMEM) over its read port after conv2 asserts `done`, and flattens it into a byte stream with a valid/ready handshake for the next layer (FC / flatten stage). OMEM holds 64 words, each four 72-bit lanes (one per PE). Each lane packs nine 8-bit max-pooled pixels, with the earliest pixel in bits [7:0]. The reader emits 16 channels × 144 pixels = 2304 bytes in channel-major order.

---
 rtl/conv2_rd_pkg.sv | 27 ++
 rtl/conv2_rd_word_fifo.sv | 58 +++++
 rtl/conv2_omem_reader.sv | 184 ++++++++++++++++++
 tb/tb_conv2_omem_reader.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv2_rd_pkg.sv
// Shared constants, FSM encoding and a byte-pick helper for the conv2 OMEM reader.
package conv2_rd_pkg;

  localparam int N_GROUPS       = 4;
  localparam int N_PE           = 4;
  localparam int WORDS_PER_CH   = 16;
  localparam int BYTES_PER_WORD = 9;
  localparam int PIX_PER_CH     = 144;
  localparam int TOTAL_BYTES    = 2304;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } rd_state_e;

  // Byte idx of a 72-bit lane; idx outside 0..8 yields zero.
  function automatic logic [7:0] pick_byte(input logic [71:0] word, input logic [3:0] idx);
    logic [7:0] b;
    b = 8'd0;
    for (int k = 0; k < BYTES_PER_WORD; k++) begin
      if (idx == 4'(k)) b = word[8*k +: 8];
    end
    return b;
  endfunction

endpackage

// File: rtl/conv2_rd_word_fifo.sv
// Two-entry 72-bit word FIFO between the OMEM read return and the byte emitter.
// A push while full is accepted only when the head is popped in the same cycle.
module conv2_rd_word_fifo (
  input  logic        clk,
  input  logic        resetn,
  input  logic        push,
  input  logic [71:0] push_data,
  input  logic        pop,
  output logic        full,
  output logic        empty,
  output logic [1:0]  count,
  output logic [71:0] head
);

  logic [1:0][71:0] mem_q, mem_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;
  logic             push_ok, pop_ok;

  assign full  = (count_q == 2'd2);
  assign empty = (count_q == 2'd0);
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  // Pointer, storage and occupancy update.
  always_comb begin
    pop_ok   = pop && !empty;
    push_ok  = push && (!full || pop_ok);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop_ok) rd_ptr_d = ~rd_ptr_q;
    if (push_ok && !pop_ok)      count_d = count_q + 2'd1;
    else if (!push_ok && pop_ok) count_d = count_q - 2'd1;
  end

  // FIFO state registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_q    <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/conv2_omem_reader.sv
// Drains conv2 OMEM (64 words x 4 lanes x 9 bytes) into a channel-major byte stream.
// Optional macro CONV2_RD_CHAN_TAG_EN adds m_chan / m_pix side-band ports.
// Handshake: a byte transfers on a rising clk edge where m_valid && m_ready; while
// m_valid is high and m_ready low, m_data/m_last (and tags) hold steady.
module conv2_omem_reader
  import conv2_rd_pkg::*;
#(
  parameter int RD_LAT = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        omem_en,
  output logic [5:0]  omem_addr,
  input  logic [71:0] omem_dout1,
  input  logic [71:0] omem_dout2,
  input  logic [71:0] omem_dout3,
  input  logic [71:0] omem_dout4,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [7:0]  m_data,
  output logic        m_last
`ifdef CONV2_RD_CHAN_TAG_EN
  ,
  output logic [3:0]  m_chan,
  output logic [7:0]  m_pix
`endif
);

  rd_state_e              state_q, state_d;
  logic [8:0]             rd_cnt_q, rd_cnt_d;      // bit 8 set once all 256 reads issued
  logic [RD_LAT-1:0]      tag_v_q, tag_v_d;
  logic [RD_LAT-1:0][1:0] tag_p_q, tag_p_d;
  logic [3:0]             byte_idx_q, byte_idx_d;
  logic [11:0]            out_cnt_q, out_cnt_d;

  logic        start_acc, issue, hs, word_end;
  logic        fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [1:0]  fifo_count;
  logic [71:0] fifo_head, lane_data;

  assign start_acc = (state_q == IDLE) && start;
  assign issue     = (state_q == RUN) && !rd_cnt_q[8] && !fifo_full &&
                     ((int'(fifo_count) + $countones(tag_v_q)) < 2);
  assign omem_en   = issue;
  assign omem_addr = {rd_cnt_q[7:6], rd_cnt_q[3:0]};

  assign m_valid   = !fifo_empty;
  assign m_data    = pick_byte(fifo_head, byte_idx_q);
  assign m_last    = m_valid && (out_cnt_q == 12'(TOTAL_BYTES - 1));
  assign hs        = m_valid && m_ready;
  assign word_end  = (byte_idx_q == 4'(BYTES_PER_WORD - 1));
  assign fifo_push = tag_v_q[RD_LAT-1];
  assign fifo_pop  = hs && word_end;

  // FSM state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (hs && m_last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == DONE);
  end

  // Read counter and lane-tag pipeline matching the OMEM read latency.
  always_comb begin
    rd_cnt_d = rd_cnt_q;
    if (start_acc)  rd_cnt_d = 9'd0;
    else if (issue) rd_cnt_d = rd_cnt_q + 9'd1;
    tag_v_d    = tag_v_q;
    tag_p_d    = tag_p_q;
    tag_v_d[0] = issue;
    tag_p_d[0] = rd_cnt_q[5:4];
    for (int i = 1; i < RD_LAT; i++) begin
      tag_v_d[i] = tag_v_q[i-1];
      tag_p_d[i] = tag_p_q[i-1];
    end
  end

  // Lane select for the returning read.
  always_comb begin
    case (tag_p_q[RD_LAT-1])
      2'd0:    lane_data = omem_dout1;
      2'd1:    lane_data = omem_dout2;
      2'd2:    lane_data = omem_dout3;
      default: lane_data = omem_dout4;
    endcase
  end

  // Emitter byte position and stream position.
  always_comb begin
    byte_idx_d = byte_idx_q;
    out_cnt_d  = out_cnt_q;
    if (start_acc) begin
      byte_idx_d = 4'd0;
      out_cnt_d  = 12'd0;
    end else if (hs) begin
      byte_idx_d = word_end ? 4'd0 : byte_idx_q + 4'd1;
      out_cnt_d  = out_cnt_q + 12'd1;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_cnt_q   <= 9'd0;
      tag_v_q    <= '0;
      tag_p_q    <= '0;
      byte_idx_q <= 4'd0;
      out_cnt_q  <= 12'd0;
    end else begin
      rd_cnt_q   <= rd_cnt_d;
      tag_v_q    <= tag_v_d;
      tag_p_q    <= tag_p_d;
      byte_idx_q <= byte_idx_d;
      out_cnt_q  <= out_cnt_d;
    end
  end

  conv2_rd_word_fifo u_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (fifo_push),
    .push_data (lane_data),
    .pop       (fifo_pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .head      (fifo_head)
  );

`ifdef CONV2_RD_CHAN_TAG_EN
  logic [3:0] chan_q, chan_d;
  logic [7:0] pix_q, pix_d;

  assign m_chan = chan_q;
  assign m_pix  = pix_q;

  // Channel / pixel tag counters, advanced on each accepted byte.
  always_comb begin
    chan_d = chan_q;
    pix_d  = pix_q;
    if (start_acc) begin
      chan_d = 4'd0;
      pix_d  = 8'd0;
    end else if (hs) begin
      if (pix_q == 8'(PIX_PER_CH - 1)) begin
        pix_d  = 8'd0;
        chan_d = chan_q + 4'd1;
      end else begin
        pix_d  = pix_q + 8'd1;
      end
    end
  end

  // Tag registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      chan_q <= 4'd0;
      pix_q  <= 8'd0;
    end else begin
      chan_q <= chan_d;
      pix_q  <= pix_d;
    end
  end
`endif

endmodule

// File: tb/tb_conv2_omem_reader.sv
// Bench for conv2_omem_reader: OMEM model, scoreboard queue fed at start, negedge monitor.
module tb_conv2_omem_reader;

  localparam int RD_LAT = 2;
  localparam int TOTAL  = 2304;

  logic        clk = 1'b0;
  logic        resetn, start, m_ready;
  logic        busy, done, omem_en, m_valid, m_last;
  logic [5:0]  omem_addr;
  logic [71:0] omem_dout1, omem_dout2, omem_dout3, omem_dout4;
  logic [7:0]  m_data;
`ifdef CONV2_RD_CHAN_TAG_EN
  logic [3:0]  m_chan;
  logic [7:0]  m_pix;
`endif

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  int         exp_idx_q[$];
  int         rx_cnt, issue_cnt, words_done, max_out;
  logic       prev_stall;
  logic [7:0] prev_data;
  bit         ready_mode;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  conv2_omem_reader #(.RD_LAT(RD_LAT)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .omem_en    (omem_en),
    .omem_addr  (omem_addr),
    .omem_dout1 (omem_dout1),
    .omem_dout2 (omem_dout2),
    .omem_dout3 (omem_dout3),
    .omem_dout4 (omem_dout4),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_last     (m_last)
`ifdef CONV2_RD_CHAN_TAG_EN
    ,
    .m_chan     (m_chan),
    .m_pix      (m_pix)
`endif
  );

  // ---------------- OMEM model (2-cycle read, keeps running through reset) ----------------
  logic [5:0] a_s1 = 6'd0;
  logic [5:0] a_s2 = 6'd0;

  function automatic logic [71:0] lane_word(input logic [5:0] a, input logic [1:0] l);
    logic [71:0] w;
    for (int k = 0; k < 9; k++) w[8*k +: 8] = {a, l} ^ 8'(k);
    return w;
  endfunction

  always @(posedge clk) begin
    if (omem_en) a_s1 <= omem_addr;
    a_s2 <= a_s1;
  end

  assign omem_dout1 = lane_word(a_s2, 2'd0);
  assign omem_dout2 = lane_word(a_s2, 2'd1);
  assign omem_dout3 = lane_word(a_s2, 2'd2);
  assign omem_dout4 = lane_word(a_s2, 2'd3);

  // ---------------- reference model ----------------
  function automatic logic [7:0] exp_byte(input int idx);
    int ch, pix, g, p, w, k, a;
    ch  = idx / 144;
    pix = idx % 144;
    g   = ch / 4;
    p   = ch % 4;
    w   = pix / 9;
    k   = pix % 9;
    a   = g * 16 + w;
    return 8'((a * 4 + p) ^ k);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_counts();
    rx_cnt     = 0;
    issue_cnt  = 0;
    words_done = 0;
    max_out    = 0;
  endtask

  task automatic start_drain();
    for (int i = 0; i < TOTAL; i++) begin
      exp_q.push_back(exp_byte(i));
      exp_idx_q.push_back(i);
    end
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", done, 1);
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("byte_count", rx_cnt, TOTAL);
    check("queue_drained", exp_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_omem_en"}, omem_en, 0);
    check({tag, "_omem_addr"}, omem_addr, 0);
    check({tag, "_m_valid"}, m_valid, 0);
    check({tag, "_m_data"}, m_data, 0);
    check({tag, "_m_last"}, m_last, 0);
`ifdef CONV2_RD_CHAN_TAG_EN
    check({tag, "_m_chan"}, m_chan, 0);
    check({tag, "_m_pix"}, m_pix, 0);
`endif
  endtask

  // Random backpressure when enabled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (ready_mode) m_ready = 1'($urandom_range(0, 1));
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (!resetn) begin
      prev_stall = 1'b0;
    end else begin
      if (omem_en) issue_cnt++;
      if (prev_stall) begin
        check("hold_valid", m_valid, 1);
        check("hold_data", m_data, prev_data);
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_byte", 1, 0);
        end else begin
          logic [7:0] eb;
          int         ei;
          eb = exp_q.pop_front();
          ei = exp_idx_q.pop_front();
          check("m_data", m_data, eb);
          check("m_last", m_last, (ei == TOTAL - 1) ? 1 : 0);
`ifdef CONV2_RD_CHAN_TAG_EN
          check("m_chan", m_chan, ei / 144);
          check("m_pix", m_pix, ei % 144);
`endif
          if (ei % 9 == 8) words_done++;
        end
        rx_cnt++;
      end
      if (issue_cnt - words_done > max_out) max_out = issue_cnt - words_done;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int n, vcnt;
    resetn     = 1'b0;
    start      = 1'b0;
    m_ready    = 1'b0;
    ready_mode = 1'b0;
    prev_stall = 1'b0;
    prev_data  = 8'd0;
    clear_counts();
    #22;
    check_reset_outputs("rst");
    @(posedge clk); #3 resetn = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_outputs("idle");

    // Test 1: m_ready high, latency and throughput.
    m_ready = 1'b1;
    clear_counts();
    for (int i = 0; i < TOTAL; i++) begin
      exp_q.push_back(exp_byte(i));
      exp_idx_q.push_back(i);
    end
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;   // edge 0 just passed
    @(negedge clk);
    n = 1;
    check("c1_busy", busy, 1);
    check("c1_omem_en", omem_en, 1);
    check("c1_omem_addr", omem_addr, 0);
    while (!m_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("first_valid_cycle", n, 2 + RD_LAT);
    vcnt = 1;
    while (!done && n < 6000) begin
      @(negedge clk);
      n++;
      if (m_valid) vcnt++;
    end
    check("done_cycle", n, 2306 + RD_LAT);
    check("valid_cycles", vcnt, TOTAL);
    check("busy_at_done", busy, 0);
    @(negedge clk);
    check("done_pulse_width", done, 0);
    check("t1_bytes", rx_cnt, TOTAL);
    check("t1_queue", exp_q.size(), 0);
    check("t1_outstanding", (max_out <= 2) ? 1 : 0, 1);

    // Test 2: random backpressure.
    clear_counts();
    ready_mode = 1'b1;
    start_drain();
    wait_done(20000);
    check("t2_outstanding", (max_out <= 2) ? 1 : 0, 1);
    ready_mode = 1'b0;

    // Test 3: m_ready low for 100 cycles right after start.
    @(posedge clk); #1 m_ready = 1'b0;
    clear_counts();
    start_drain();
    repeat (100) @(negedge clk);
    check("t3_reads_issued", issue_cnt, 2);
    check("t3_omem_en_low", omem_en, 0);
    check("t3_valid_waiting", m_valid, 1);
    @(posedge clk); #1 m_ready = 1'b1;
    wait_done(6000);

    // Test 4: start re-pulsed mid-drain is ignored.
    clear_counts();
    ready_mode = 1'b1;
    start_drain();
    repeat (300) @(negedge clk);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done(20000);
    ready_mode = 1'b0;
    repeat (5) @(negedge clk);
    check("t4_idle_busy", busy, 0);
    check("t4_idle_valid", m_valid, 0);

    // Test 5: reset at byte 500, then restart.
    @(posedge clk); #1 m_ready = 1'b1;
    clear_counts();
    start_drain();
    n = 0;
    while (rx_cnt < 500 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("t5_reached_500", (rx_cnt >= 500) ? 1 : 0, 1);
    #2 resetn = 1'b0;
    #1;
    check_reset_outputs("t5_rst");
    exp_q.delete();
    exp_idx_q.delete();
    clear_counts();
    @(posedge clk); #3 resetn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("t5_no_stale_valid", m_valid, 0);
    end
    check_reset_outputs("t5_after");
    start_drain();
    wait_done(6000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog.
  initial begin
    #3000000;
    $display("FAIL watchdog timeout actual=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
